alu_arbiter: RTL and testbench

- Shares the single combinational Alu between two requesters: port 0 is the execute stage and port 1 is the branch/compare helper.
- Arbitration is round-robin (or fixed priority) with valid/ready request handshakes and one registered response slot per requester.
- An optional lock lets one requester hold the ALU across a multi-op sequence; a lock timeout prevents starvation.
- Sits between the requesters and the control_hazard_alu_if signal set (oprnd1, oprnd2, alucode, alurst, vldflg, cryflg, ngtflg, zroflg).

---
 rtl/cpu_types_pkg.sv | 35 +++
 rtl/rr_pick2.sv | 20 ++
 rtl/alu_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared ALU opcode, flag and arbiter state types
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef struct packed {
        logic vld;
        logic cry;
        logic ngt;
        logic zro;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Legal codes are packed densely from SLL up to SLTU.
    function automatic logic legal_op(input logic [3:0] op);
        return op <= ALU_SLTU;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin / fixed-priority picker
module rr_pick2 (
    input  logic [1:0] elig,
    input  logic       last,
    input  logic       prio0,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (elig)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On a tie the requester that did not win last time goes first.
            2'b11:   gnt = (prio0 || last) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between two requesters
module alu_arbiter
    import cpu_types_pkg::*;
#(
    parameter bit          PRIO0    = 1'b0,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_lock,
    input  logic [1:0][3:0]  req_op,
    input  logic [1:0][31:0] req_a,
    input  logic [1:0][31:0] req_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [1:0][31:0] rsp_result,
    output logic [1:0][3:0]  rsp_flags,
    output logic [1:0]       rsp_err,
    output logic             lock_to,
    output logic [3:0]       alu_code,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_rst,
    input  alu_flags_t       alu_flags
);

    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    arb_state_t       state_q, state_d;
    logic             last_gnt_q, last_gnt_d;
    logic [7:0]       lock_cnt_q, lock_cnt_d;
    logic             lock_to_q, lock_to_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [1:0][31:0] rsp_result_q, rsp_result_d;
    logic [1:0][3:0]  rsp_flags_q, rsp_flags_d;
    logic [1:0]       rsp_err_q, rsp_err_d;

    logic [1:0] elig, rr_gnt, gnt;
    logic       gidx, own;

    assign elig = req_valid & (~rsp_valid_q | rsp_ready);

    rr_pick2 u_pick (
        .elig  (elig),
        .last  (last_gnt_q),
        .prio0 (PRIO0),
        .gnt   (rr_gnt)
    );

    always_comb begin
        gnt = 2'b00;
        if (!RST) begin
            unique case (state_q)
                IDLE:    gnt = rr_gnt;
                OWN0:    gnt = {1'b0, elig[0]};
                OWN1:    gnt = {elig[1], 1'b0};
                default: gnt = 2'b00;
            endcase
        end
    end

    assign gidx      = gnt[1];
    assign own       = (state_q == OWN1);
    assign req_ready = gnt;

    always_comb begin
        alu_code = ALU_ADD;
        alu_a    = '0;
        alu_b    = '0;
        if (|gnt) begin
            alu_code = req_op[gidx];
            alu_a    = req_a[gidx];
            alu_b    = req_b[gidx];
        end
    end

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        for (int i = 0; i < 2; i++) begin
            if (gnt[i]) begin
                rsp_valid_d[i] = 1'b1;
                if (legal_op(req_op[i])) begin
                    rsp_result_d[i] = alu_rst;
                    rsp_flags_d[i]  = alu_flags;
                    rsp_err_d[i]    = 1'b0;
                end else begin
                    rsp_result_d[i] = '0;
                    rsp_flags_d[i]  = '0;
                    rsp_err_d[i]    = 1'b1;
                end
            end else if (rsp_ready[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        lock_to_d  = 1'b0;
        last_gnt_d = (|gnt) ? gidx : last_gnt_q;
        unique case (state_q)
            IDLE: begin
                lock_cnt_d = '0;
                if ((|gnt) && req_lock[gidx]) begin
                    state_d    = gidx ? OWN1 : OWN0;
                    lock_cnt_d = 8'd1;
                end
            end
            OWN0, OWN1: begin
                // Timeout wins over everything and hands the next tie to the other side.
                if (lock_cnt_q == LOCK_MAX_C) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                    lock_to_d  = 1'b1;
                    last_gnt_d = own;
                end else if (!req_lock[own]) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            last_gnt_q   <= 1'b1;
            lock_cnt_q   <= '0;
            lock_to_q    <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            lock_cnt_q   <= lock_cnt_d;
            lock_to_q    <= lock_to_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;
    assign lock_to    = lock_to_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
    import cpu_types_pkg::*;

    logic             CLK = 1'b0;
    logic             RST;
    logic [1:0]       req_valid, req_lock, rsp_ready;
    logic [1:0][3:0]  req_op;
    logic [1:0][31:0] req_a, req_b;

    logic [1:0]       req_ready, rsp_valid, rsp_err;
    logic [1:0][31:0] rsp_result;
    logic [1:0][3:0]  rsp_flags;
    logic             lock_to;
    logic [3:0]       alu_code;
    logic [31:0]      alu_a, alu_b, alu_rst;
    logic [3:0]       alu_flags;
    logic [35:0]      alu_out;

    logic [1:0]       req_ready_p, rsp_valid_p, rsp_err_p;
    logic [1:0][31:0] rsp_result_p;
    logic [1:0][3:0]  rsp_flags_p;
    logic             lock_to_p;
    logic [3:0]       alu_code_p;
    logic [31:0]      alu_a_p, alu_b_p, alu_rst_p;
    logic [3:0]       alu_flags_p;
    logic [35:0]      alu_out_p;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    // Reference ALU: returns {vld, cry, ngt, zro, result}; illegal codes give junk.
    function automatic logic [35:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic [3:0]  f;
        s = '0;
        r = '0;
        f = '0;
        case (op)
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                f[2] = s[32];
                f[3] = (a[31] == b[31]) && (r[31] != a[31]);
            end
            ALU_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[31:0];
                f[2] = s[32];
                f[3] = (a[31] != b[31]) && (r[31] != a[31]);
            end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'b0, a < b};
            default:  return {4'hF, 32'hDEADBEEF};
        endcase
        f[1] = r[31];
        f[0] = (r == 32'd0);
        return {f, r};
    endfunction

    assign alu_out     = alu_model(alu_code, alu_a, alu_b);
    assign alu_rst     = alu_out[31:0];
    assign alu_flags   = alu_out[35:32];
    assign alu_out_p   = alu_model(alu_code_p, alu_a_p, alu_b_p);
    assign alu_rst_p   = alu_out_p[31:0];
    assign alu_flags_p = alu_out_p[35:32];

    alu_arbiter #(.PRIO0(1'b0), .LOCK_MAX(4)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
        .req_lock(req_lock), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .lock_to(lock_to),
        .alu_code(alu_code), .alu_a(alu_a), .alu_b(alu_b),
        .alu_rst(alu_rst), .alu_flags(alu_flags)
    );

    alu_arbiter #(.PRIO0(1'b1), .LOCK_MAX(4)) dut_p (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready_p),
        .req_lock(req_lock), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid_p), .rsp_ready(rsp_ready), .rsp_result(rsp_result_p),
        .rsp_flags(rsp_flags_p), .rsp_err(rsp_err_p), .lock_to(lock_to_p),
        .alu_code(alu_code_p), .alu_a(alu_a_p), .alu_b(alu_b_p),
        .alu_rst(alu_rst_p), .alu_flags(alu_flags_p)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = 2'b00;
        req_lock  = 2'b00;
        rsp_ready = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle_inputs();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    typedef struct {
        int          port;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
        logic        err;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{0, ALU_ADD,  32'd12345,     32'd6789,      32'd19134,     4'b0000, 1'b0};
        tbl[1]  = '{0, ALU_SUB,  32'd23456,     32'd543,       32'd22913,     4'b0000, 1'b0};
        tbl[2]  = '{1, ALU_SLTU, 32'h0,         32'hFFFFFFFF,  32'd1,         4'b0000, 1'b0};
        tbl[3]  = '{1, ALU_SLT,  32'h0,         32'hFFFFFFFF,  32'd0,         4'b0001, 1'b0};
        tbl[4]  = '{0, ALU_ADD,  32'hFFFFFFFF,  32'd1,         32'd0,         4'b0101, 1'b0};
        tbl[5]  = '{1, ALU_ADD,  32'h7FFFFFFF,  32'd1,         32'h80000000,  4'b1010, 1'b0};
        tbl[6]  = '{0, ALU_SUB,  32'd5,         32'd7,         32'hFFFFFFFE,  4'b0110, 1'b0};
        tbl[7]  = '{1, ALU_AND,  32'hF0F0F0F0,  32'h0FF00FF0,  32'h00F000F0,  4'b0000, 1'b0};
        tbl[8]  = '{0, ALU_OR,   32'h00FF0000,  32'h000000FF,  32'h00FF00FF,  4'b0000, 1'b0};
        tbl[9]  = '{1, ALU_XOR,  32'hAAAAAAAA,  32'hFFFFFFFF,  32'h55555555,  4'b0000, 1'b0};
        tbl[10] = '{0, ALU_NOR,  32'h0,         32'h0,         32'hFFFFFFFF,  4'b0010, 1'b0};
        tbl[11] = '{1, ALU_SLL,  32'd1,         32'd4,         32'd16,        4'b0000, 1'b0};
        tbl[12] = '{0, ALU_SRL,  32'h80000000,  32'd31,        32'd1,         4'b0000, 1'b0};
        tbl[13] = '{0, 4'b1111,  32'd3,         32'd4,         32'd0,         4'b0000, 1'b1};

        do_reset();
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_result", 64'(rsp_result), 64'd0);
        chk("reset_rsp_flags_err", 64'({rsp_flags, rsp_err}), 64'd0);
        chk("reset_lock_to", 64'(lock_to), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_alu_idle", 64'({alu_code, alu_a}), 64'({4'(ALU_ADD), 32'd0}));

        // Single ops, one requester at a time.
        for (int i = 0; i < 14; i++) begin
            req_valid = 2'b00;
            req_valid[tbl[i].port] = 1'b1;
            req_op[tbl[i].port] = tbl[i].op;
            req_a[tbl[i].port]  = tbl[i].a;
            req_b[tbl[i].port]  = tbl[i].b;
            rsp_ready = 2'b11;
            #1;
            chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(2'b01 << tbl[i].port));
            chk($sformatf("vec%0d_alu_a", i), 64'(alu_a), 64'(tbl[i].a));
            @(negedge CLK);
            req_valid = 2'b00;
            #1;
            chk($sformatf("vec%0d_rsp_valid", i), 64'(rsp_valid[tbl[i].port]), 64'd1);
            chk($sformatf("vec%0d_result", i), 64'(rsp_result[tbl[i].port]), 64'(tbl[i].res));
            chk($sformatf("vec%0d_flags", i), 64'(rsp_flags[tbl[i].port]), 64'(tbl[i].fl));
            chk($sformatf("vec%0d_err", i), 64'(rsp_err[tbl[i].port]), 64'(tbl[i].err));
        end

        // Round-robin alternation under continuous contention.
        do_reset();
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        req_op[0] = ALU_SUB;  req_a[0] = 32'd23456; req_b[0] = 32'd543;
        req_op[1] = ALU_SLTU; req_a[1] = 32'd0;     req_b[1] = 32'hFFFFFFFF;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (k > 0)
                chk($sformatf("rr%0d_result", k), 64'(rsp_result[(k - 1) % 2]),
                    ((k - 1) % 2 == 0) ? 64'd22913 : 64'd1);
            if (k < 4) begin
                chk($sformatf("rr%0d_ready", k), 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
                chk($sformatf("prio%0d_ready", k), 64'(req_ready_p), 64'd1);
            end
            @(negedge CLK);
        end

        // Response backpressure on requester 1.
        do_reset();
        req_valid = 2'b10;
        req_op[1] = ALU_SLT; req_a[1] = 32'd0; req_b[1] = 32'hFFFFFFFF;
        #1;
        chk("bp_first_ready", 64'(req_ready), 64'd2);
        @(negedge CLK);
        req_valid = 2'b11;
        rsp_ready = 2'b01;
        req_op[1] = ALU_ADD; req_a[1] = 32'd1; req_b[1] = 32'd2;
        req_op[0] = ALU_ADD; req_a[0] = 32'd5; req_b[0] = 32'd5;
        #1;
        chk("bp_slt_result", 64'(rsp_result[1]), 64'd0);
        chk("bp_slt_flags", 64'(rsp_flags[1]), 64'b0001);
        chk("bp_blocked_ready_a", 64'(req_ready), 64'd1);
        @(negedge CLK);
        #1;
        chk("bp_blocked_ready_b", 64'(req_ready), 64'd1);
        chk("bp_req0_result", 64'(rsp_result[0]), 64'd10);
        @(negedge CLK);
        rsp_ready = 2'b11;
        #1;
        chk("bp_release_ready", 64'(req_ready), 64'd2);
        @(negedge CLK);
        req_valid = 2'b00;
        #1;
        chk("bp_req1_result", 64'(rsp_result[1]), 64'd3);
        chk("bp_slots_after", 64'(rsp_valid), 64'b10);
        @(negedge CLK);
        #1;
        chk("bp_slots_drained", 64'(rsp_valid), 64'b00);

        // Voluntary lock over three ops.
        do_reset();
        req_valid = 2'b11;
        req_lock  = 2'b01;
        rsp_ready = 2'b11;
        req_op[0] = ALU_ADD; req_a[0] = 32'd1; req_b[0] = 32'd1;
        req_op[1] = ALU_ADD; req_a[1] = 32'd2; req_b[1] = 32'd2;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) req_lock = 2'b00;
            #1;
            chk($sformatf("lock%0d_ready", k), 64'(req_ready), (k < 3) ? 64'd1 : 64'd2);
            @(negedge CLK);
        end

        // Lock timeout with LOCK_MAX=4.
        do_reset();
        req_valid = 2'b01;
        req_lock  = 2'b01;
        rsp_ready = 2'b11;
        req_op[0] = ALU_ADD; req_a[0] = 32'd7; req_b[0] = 32'd8;
        #1;
        chk("to_first_ready", 64'(req_ready), 64'd1);
        @(negedge CLK);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("to_hold%0d", k), 64'({lock_to, req_ready}), 64'b001);
            @(negedge CLK);
        end
        #1;
        chk("to_pulse", 64'(lock_to), 64'd1);
        chk("to_req1_ready", 64'(req_ready), 64'd2);
        @(negedge CLK);
        #1;
        chk("to_pulse_end", 64'(lock_to), 64'd0);
        @(negedge CLK);

        // Reset while locked with a response pending.
        do_reset();
        req_valid = 2'b01;
        req_lock  = 2'b01;
        req_op[0] = ALU_ADD; req_a[0] = 32'd1; req_b[0] = 32'd2;
        @(negedge CLK);
        #1;
        chk("rl_pending", 64'(rsp_valid), 64'b01);
        RST = 1'b1;
        idle_inputs();
        @(negedge CLK);
        RST = 1'b0;
        req_valid = 2'b10;
        #1;
        chk("rl_rsp_cleared", 64'(rsp_valid), 64'd0);
        chk("rl_lock_to", 64'(lock_to), 64'd0);
        chk("rl_idle_grant", 64'(req_ready), 64'd2);
        @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
